// File: rtl/sdram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_sched_pkg
// Description : Shared types and default geometry for the SDRAM burst scheduler.
// Revision    : 1.0
// ============================================================================
package sdram_sched_pkg;

    localparam int unsigned C_BURST_LEN = 8;
    localparam int unsigned C_ADDR_W    = 22;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_BURST = 3'd4
    } sched_state_e;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/sdram_rw_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rw_sched_if
// Description : FIFO levels, sdram_ctrl request/ack handshake and status bus.
// Revision    : 1.0
// ============================================================================
interface sdram_rw_sched_if #(
    parameter int ADDR_W = 22,
    parameter int LVL_W  = 9
);
    logic              init_done;
    logic [LVL_W-1:0]  wrf_usedw;
    logic [LVL_W-1:0]  rdf_usedw;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_addr;
    logic [ADDR_W:0]   sdram_level;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  init_done, wrf_usedw, rdf_usedw, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_rd_req, sdram_addr, sdram_level, busy, err_timeout
    );

    modport slave (
        output init_done, wrf_usedw, rdf_usedw, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_rd_req, sdram_addr, sdram_level, busy, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sdram_addr_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sdram_addr_ptr
// Description : Burst-granular circular address pointer with wrap at ADDR_DEPTH.
// Revision    : 1.0
// ============================================================================
module sdram_addr_ptr #(
    parameter int ADDR_W     = 22,
    parameter int ADDR_DEPTH = 4194304,
    parameter int BURST_LEN  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              adv_i,
    output logic [ADDR_W-1:0]      ptr_o
);
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W:0]   w_sum;

    // Extra bit lets the sum reach ADDR_DEPTH == 2^ADDR_W without aliasing to 0.
    assign w_sum = {1'b0, ptr_q} + (ADDR_W+1)'(BURST_LEN);

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (w_sum == (ADDR_W+1)'(ADDR_DEPTH)) ? '0 : w_sum[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule
`default_nettype wire

// File: rtl/sdram_rw_sched.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rw_sched
// Description : Arbitrates write/read bursts onto sdram_ctrl; SDRAM is a circular buffer.
// Revision    : 1.0
// ============================================================================
module sdram_rw_sched
    import sdram_sched_pkg::*;
#(
    parameter int BURST_LEN  = C_BURST_LEN,
    parameter int ADDR_W     = C_ADDR_W,
    parameter int ADDR_DEPTH = 4194304,
    parameter int LVL_W      = 9,
    parameter int RDF_DEPTH  = 256,
    parameter int TIMEOUT    = 4095
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sdram_rw_sched_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W:0]  C_LVL_BURST = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]  C_LVL_FULL  = (ADDR_W+1)'(ADDR_DEPTH);
    localparam logic [ADDR_W:0]  C_LVL_WRMAX = (ADDR_W+1)'(ADDR_DEPTH - BURST_LEN);
    localparam logic [LVL_W-1:0] C_FIFO_BURST = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] C_RDF_MAX    = LVL_W'(RDF_DEPTH - BURST_LEN);

    sched_state_e      state_q, state_d;
    grant_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;

    logic              wr_adv, rd_adv;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_ok, rd_ok, gnt_wr, gnt_rd;

    sdram_addr_ptr #(.ADDR_W(ADDR_W), .ADDR_DEPTH(ADDR_DEPTH), .BURST_LEN(BURST_LEN)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (wr_adv),
        .ptr_o (wr_ptr)
    );

    sdram_addr_ptr #(.ADDR_W(ADDR_W), .ADDR_DEPTH(ADDR_DEPTH), .BURST_LEN(BURST_LEN)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (rd_adv),
        .ptr_o (rd_ptr)
    );

    assign wr_ok = bus.init_done & ~err_q & (bus.wrf_usedw >= C_FIFO_BURST) & (level_q <= C_LVL_WRMAX);
    assign rd_ok = bus.init_done & ~err_q & (level_q >= C_LVL_BURST) & (bus.rdf_usedw <= C_RDF_MAX);

    // Round-robin on ties: the side that did not win last time goes first.
    assign gnt_wr = wr_ok & (~rd_ok | (last_q == RD));
    assign gnt_rd = rd_ok & ~gnt_wr;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        level_d = level_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        wr_adv  = 1'b0;
        rd_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_wr) begin
                    state_d = WR_REQ;
                    last_d  = WR;
                    addr_d  = wr_ptr;
                    tmo_d   = '0;
                end else if (gnt_rd) begin
                    state_d = RD_REQ;
                    last_d  = RD;
                    addr_d  = rd_ptr;
                    tmo_d   = '0;
                end
            end
            WR_REQ, RD_REQ: begin
                if ((state_q == WR_REQ) ? bus.sdram_wr_ack : bus.sdram_rd_ack) begin
                    state_d = (state_q == WR_REQ) ? WR_BURST : RD_BURST;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WR_BURST: begin
                if (!bus.sdram_wr_ack) begin
                    wr_adv  = 1'b1;
                    level_d = level_q + C_LVL_BURST;
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                if (!bus.sdram_rd_ack) begin
                    rd_adv  = 1'b1;
                    level_d = level_q - C_LVL_BURST;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= RD;
            addr_q  <= '0;
            level_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            level_q <= level_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign bus.sdram_wr_req = (state_q == WR_REQ);
    assign bus.sdram_rd_req = (state_q == RD_REQ);
    assign bus.sdram_addr   = addr_q;
    assign bus.sdram_level  = level_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.err_timeout  = err_q;

    a_level_bound: assert property (@(posedge clk) disable iff (rst) level_q <= C_LVL_FULL);
    a_one_req:     assert property (@(posedge clk) disable iff (rst)
                                    !((state_q == WR_REQ) && (state_q == RD_REQ)) && !(bus.sdram_wr_req && bus.sdram_rd_req));
endmodule
`default_nettype wire

// File: tb/tb_sdram_rw_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_rw_sched
// Description : Directed bench for sdram_rw_sched with a 32-word circular buffer.
// Revision    : 1.0
// ============================================================================
module tb_sdram_rw_sched;
    localparam int AW    = 22;
    localparam int LW    = 9;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_rw_sched_if #(.ADDR_W(AW), .LVL_W(LW)) bus ();

    sdram_rw_sched #(
        .BURST_LEN (8),
        .ADDR_W    (AW),
        .ADDR_DEPTH(DEPTH),
        .LVL_W     (LW),
        .RDF_DEPTH (256),
        .TIMEOUT   (4095)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic req_of(input bit wr);
        return wr ? bus.sdram_wr_req : bus.sdram_rd_req;
    endfunction

    task automatic wait_req(input bit wr, output int waited);
        waited = 0;
        while (!req_of(wr) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk(wr ? "wr_req_seen" : "rd_req_seen", 32'(req_of(wr)), 1);
    endtask

    task automatic set_ack(input bit wr, input logic v);
        if (wr) bus.sdram_wr_ack = v;
        else    bus.sdram_rd_ack = v;
    endtask

    // One burst: wait for request, delay dly cycles, raise ack for win cycles.
    task automatic burst(input bit wr, input int dly, input int win,
                         input int exp_addr, input int exp_lvl, output int waited);
        wait_req(wr, waited);
        chk("addr", 32'(bus.sdram_addr), exp_addr);
        chk("other_req", 32'(req_of(!wr)), 0);
        repeat (dly) @(negedge clk);
        chk("req_hold", 32'(req_of(wr)), 1);
        set_ack(wr, 1'b1);
        @(negedge clk);
        chk("req_drop", 32'(req_of(wr)), 0);
        repeat (win - 1) @(negedge clk);
        set_ack(wr, 1'b0);
        @(negedge clk);
        chk("busy_done", 32'(bus.busy), 0);
        chk("level", 32'(bus.sdram_level), exp_lvl);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen = seen | bus.sdram_wr_req | bus.sdram_rd_req | bus.busy;
        end
        chk(tag, 32'(seen), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        rst = 1'b1;
        bus.init_done    = 1'b0;
        bus.wrf_usedw    = '0;
        bus.rdf_usedw    = '0;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 32'(bus.sdram_wr_req), 0);
        chk("rst_rd_req", 32'(bus.sdram_rd_req), 0);
        chk("rst_addr",   32'(bus.sdram_addr), 0);
        chk("rst_level",  32'(bus.sdram_level), 0);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_err",    32'(bus.err_timeout), 0);
        rst = 1'b0;

        // No grants before init_done.
        bus.wrf_usedw = 9'd8;
        bus.rdf_usedw = 9'd249;
        expect_quiet("no_init", 5);
        bus.init_done = 1'b1;

        // Write-only stream; rdf_usedw=249 blocks reads.
        burst(1'b1, 1, 9, 0, 8, w);
        chk("wr_latency", w, 1);
        burst(1'b1, 0, 3, 8, 16, w);
        burst(1'b1, 0, 1, 16, 24, w);

        // Contention: last grant was WR, so RD goes first, then alternate.
        bus.rdf_usedw = 9'd0;
        bus.wrf_usedw = 9'd32;
        burst(1'b0, 0, 4, 0, 16, w);
        burst(1'b1, 0, 4, 24, 24, w);
        burst(1'b0, 0, 4, 8, 16, w);
        burst(1'b1, 0, 4, 0, 24, w);
        burst(1'b0, 0, 4, 16, 16, w);

        // Fill to the top; level 32 blocks writes, rdf 249 blocks reads.
        bus.rdf_usedw = 9'd249;
        burst(1'b1, 0, 4, 8, 24, w);
        burst(1'b1, 0, 4, 16, 32, w);
        expect_quiet("full_gate", 20);

        // rdf_usedw=248 re-enables reads; drain to empty.
        bus.rdf_usedw = 9'd248;
        burst(1'b0, 0, 4, 24, 24, w);
        chk("rd_latency", w, 1);
        bus.wrf_usedw = 9'd0;
        burst(1'b0, 0, 4, 0, 16, w);
        burst(1'b0, 0, 4, 8, 8, w);
        burst(1'b0, 0, 4, 16, 0, w);
        expect_quiet("empty_gate", 20);

        // Timeout: request never acknowledged.
        bus.wrf_usedw = 9'd8;
        wait_req(1'b1, w);
        chk("tmo_addr", 32'(bus.sdram_addr), 24);
        cnt = 0;
        while (bus.sdram_wr_req && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo_len",   cnt, 4096);
        chk("tmo_err",   32'(bus.err_timeout), 1);
        chk("tmo_level", 32'(bus.sdram_level), 0);
        expect_quiet("tmo_block", 20);
        chk("tmo_sticky", 32'(bus.err_timeout), 1);

        // Reset clears the sticky error; then abort a read burst with rst.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 32'(bus.err_timeout), 0);
        bus.rdf_usedw = 9'd248;
        burst(1'b1, 0, 2, 0, 8, w);
        wait_req(1'b0, w);
        chk("rb_addr", 32'(bus.sdram_addr), 0);
        bus.sdram_rd_ack = 1'b1;
        @(negedge clk);
        chk("rb_in_burst", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        bus.sdram_rd_ack = 1'b0;
        chk("rb_wr_req", 32'(bus.sdram_wr_req), 0);
        chk("rb_rd_req", 32'(bus.sdram_rd_req), 0);
        chk("rb_addr0",  32'(bus.sdram_addr), 0);
        chk("rb_level",  32'(bus.sdram_level), 0);
        chk("rb_busy",   32'(bus.busy), 0);
        rst = 1'b0;
        wait_req(1'b1, w);
        chk("post_rst_wr_addr", 32'(bus.sdram_addr), 0);
        chk("post_rst_latency", w, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_rw_sched.md
Name: sdram_rw_sched

Overview:
- Burst scheduler that shares the single `sdram_ctrl` read/write port between a write-side FIFO (camera/host ingress) and a read-side FIFO (display/host egress).
- Decides when a burst is worthwhile and raises `sdram_wr_req` / `sdram_rd_req`.
- Tracks the `sdram_ctrl` ack windows to detect burst completion.
- Owns the SDRAM write/read address pointers and the occupancy count, so the SDRAM behaves as one large circular buffer.

Parameters:
- BURST_LEN, 8: words per burst; equals the `sdram_ctrl` burst.
- ADDR_W, 22: word address width ({bank[1:0], row[11:0], col[7:0]}).
- ADDR_DEPTH, 4194304: circular-buffer size in words; multiple of BURST_LEN, ≤ 2^ADDR_W.
- LVL_W, 9: FIFO used-word width.
- RDF_DEPTH, 256: read FIFO capacity in words.
- TIMEOUT, 4095: maximum cycles from request assertion to first ack.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- init_done  in  1  SDRAM initialisation complete
- wrf_usedw  in  LVL_W  words waiting in the write FIFO
- rdf_usedw  in  LVL_W  words held in the read FIFO
- sdram_wr_ack  in  1  write-data window from `sdram_ctrl`
- sdram_rd_ack  in  1  read-data window from `sdram_ctrl`
- sdram_wr_req  out  1  write burst request
- sdram_rd_req  out  1  read burst request
- sdram_addr  out  ADDR_W  burst start address for the current/next burst
- sdram_level  out  ADDR_W+1  words stored in SDRAM
- busy  out  1  a burst is requested or in progress
- err_timeout  out  1  sticky; set when a request goes unacknowledged

Behaviour:
- All state is registered on the clk rising edge. rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, both pointers 0, level 0, last_grant = RD (so the first tie goes to write).
- Eligibility, combinational, evaluated only in IDLE:
  - wr_ok = init_done & !err_timeout & (wrf_usedw ≥ BURST_LEN) & (level ≤ ADDR_DEPTH − BURST_LEN)
  - rd_ok = init_done & !err_timeout & (level ≥ BURST_LEN) & (rdf_usedw ≤ RDF_DEPTH − BURST_LEN)
- Arbitration:
  - Only one of wr_ok/rd_ok true: grant it.
  - Both true: grant the one opposite to last_grant (round-robin).
  - last_grant updates on grant.
- States:
  - IDLE:
    - On grant → WR_REQ or RD_REQ.
    - Next cycle: the corresponding req = 1, sdram_addr = that pointer, tmo counter cleared.
  - WR_REQ / RD_REQ:
    - req held high and tmo counter increments.
    - First cycle the matching ack = 1 → req deasserts on the next edge; state → WR_BURST / RD_BURST.
    - tmo == TIMEOUT with no ack → req = 0, err_timeout = 1, pointers and level unchanged, → IDLE.
  - WR_BURST / RD_BURST:
    - Wait for the matching ack = 0.
    - On that cycle: pointer += BURST_LEN, wrapping to 0 when the sum equals ADDR_DEPTH.
    - level += BURST_LEN (write) or −= BURST_LEN (read).
    - → IDLE.
- Latency:
  - Grant to req high: 1 cycle.
  - Ack fall to pointer/level update and return to IDLE: 1 cycle.
  - Earliest next request: 1 cycle after that.
- Ack-window length is not checked; completion is defined solely by the falling edge of ack.
- Acks other than the one matching the active request are ignored in every state.
- Acks in IDLE are ignored.
- busy = (state != IDLE).
- Only one request is ever outstanding: wr_req and rd_req are never both 1, so level never sees simultaneous increment and decrement.
- Level never exceeds ADDR_DEPTH and never underflows (guaranteed by eligibility); this is an assertion target.
- err_timeout is cleared only by rst. While it is set, no new grants are made.
- init_done falling mid-burst: the current burst completes normally; no new grants are made.
- rst mid-burst: returns everything to reset values immediately. The pending `sdram_ctrl` transaction is abandoned, since `sdram_ctrl` is reset on the same rst source.

Decomposition:
- Package `sdram_sched_pkg`:
  - state enum (IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST)
  - grant enum (WR, RD)
  - default BURST_LEN / ADDR_W constants shared with the address-mapping logic
- Sub-module `sdram_addr_ptr`: parameterised ADDR_W/ADDR_DEPTH/BURST_LEN pointer with an advance input and wrap. Instantiated twice, once for write and once for read.

Test Plan:
- Write-only stream:
  - Stimulus: init_done = 1, wrf_usedw = 8, ack model gives 1-cycle delay then 9-cycle wr_ack.
  - Expected: wr_req high 1 cycle after grant and dropped the cycle after ack rises.
  - Expected after ack falls: write pointer = 8, level = 8.
- Contention:
  - Stimulus: level = 16, wrf_usedw = 32, rdf_usedw = 0.
  - Expected: grants alternate WR, RD, WR, RD.
  - Expected: pointers advance in steps of 8; level oscillates 24/16.
- Wrap:
  - Stimulus: ADDR_DEPTH = 32 override; perform 4 writes then a 5th write.
  - Expected: 4th write address = 24; 5th write address = 0, issued only after reads have made room (level ≤ 24).
- Full/empty gating:
  - Stimulus 1: level = ADDR_DEPTH. Expected: no wr_req.
  - Stimulus 2: level = 7. Expected: no rd_req.
  - Stimulus 3: rdf_usedw = 249 (RDF_DEPTH 256). Expected: no rd_req.
  - Stimulus 4: rdf_usedw = 248. Expected: rd_req issued.
- Timeout:
  - Stimulus: ack never asserted.
  - Expected: req drops at tmo = 4095; err_timeout = 1; pointers and level unchanged; no further requests until rst.
- Reset:
  - Stimulus: rst pulsed during RD_BURST.
  - Expected next cycle: all outputs 0, state IDLE, pointers 0; the first grant after release goes to WR.
